// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder:
// state encodings, default geometry, counter width, range helper.
package data_mem_responder_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LATENCY = 2;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Any set bit above the implemented word index is out of range.
  function automatic logic out_of_range(
    input logic [31:0] a,
    input int unsigned aw
  );
    if (aw >= 32) return 1'b0;
    return (a >> aw) != 32'd0;
  endfunction

endpackage

// File: rtl/dm_storage.sv
// Word storage for the data-memory responder.
// Ports: clk, rst (sync clear), we/wdata write, re read, addr shared, rdata registered.
module dm_storage #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[addr] <= wdata;
      end
      if (re) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts load/store, waits LATENCY cycles, responds.
// Ports: clk, rst, req/we/addr/wdata in; ready, busy, rvalid, rdata, err out.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              busy,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  if (LATENCY > CNT_MAX || LATENCY < 0) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be 0..15");
  end

  localparam logic [CNT_W-1:0] LAT_CNT =
    CNT_W'(LATENCY);
  localparam bit LAT0 = (LATENCY == 0);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  count;

  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_oor;

  logic              accept;
  logic              go_resp;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_oor;
  logic              st_we;
  logic              st_re;
  logic [DATA_W-1:0] mem_q;

  assign accept = req & ready;

  // With zero latency the accept edge is also
  // the commit edge, so storage must see the
  // live request rather than the latched copy.
  assign cur_we    = accept ? we    : lat_we;
  assign cur_addr  = accept ? addr  : lat_addr;
  assign cur_wdata = accept ? wdata : lat_wdata;
  assign cur_oor   = out_of_range(cur_addr, ADDR_W);

  assign go_resp =
    (state == ST_WAIT && count == CNT_W'(1)) ||
    (accept && LAT0);

  assign st_we = go_resp &  cur_we & ~cur_oor;
  assign st_re = go_resp & ~cur_we & ~cur_oor;

  assign lat_oor = out_of_range(lat_addr, ADDR_W);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          state_nxt = LAT0 ? ST_RESP : ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (count == CNT_W'(1)) begin
          state_nxt = ST_RESP;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic; the latches always describe
  // the request being answered in RESP.
  always_comb begin
    ready  = (state != ST_WAIT);
    rvalid = (state == ST_RESP);
    busy   = (req & ~ready) |
             (state == ST_WAIT);
    err    = rvalid & lat_oor;
    rdata  = '0;
    if (rvalid && !lat_we && !lat_oor) begin
      rdata = mem_q;
    end
  end

  // Wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (accept) begin
      count <= LAT_CNT;
    end else if (state == ST_WAIT) begin
      count <= count - CNT_W'(1);
    end
  end

  // Request latch
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_we    <= we;
      lat_addr  <= addr;
      lat_wdata <= wdata;
    end
  end

  dm_storage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_storage (
    .clk   (clk),
    .rst   (rst),
    .we    (st_we),
    .re    (st_re),
    .addr  (cur_addr[ADDR_W-1:0]),
    .wdata (cur_wdata),
    .rdata (mem_q)
  );

endmodule
